mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Sequencer and arbiter for the single byte-wide RAM port, shared by two requesters: the instruction-fetch queue and the load/store buffer. It serialises every access into byte-wide RAM cycles, selects the requester fairly, and assembles or splits 32-bit words. It returns one completion pulse per transaction, and supports flushing speculative reads on a branch mispredict.

## Interface
- ADDR_WIDTH, 32, width of all address ports
- FAIR, 1, 1 = alternate priority after contention; 0 = load/store always wins
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request (level); hold until if_done
- if_addr  in  ADDR_WIDTH  fetch address; stable while if_req high
- if_done  out  1  one-cycle completion pulse
- if_data  out  32  fetched word, little-endian; valid while if_done high
- ls_req  in  1  load/store request (level); hold until ls_done
- ls_we  in  1  1 = store, 0 = load
- ls_size  in  2  00 byte, 01 half, 10/11 word
- ls_addr  in  ADDR_WIDTH  base byte address
- ls_wdata  in  32  store data, with byte k written to ls_addr+k
- ls_done  out  1  one-cycle completion pulse
- ls_rdata  out  32  load data, zero-extended to 32 bits; valid while ls_done high
- flush  in  1  abort speculative reads (fetch and loads)
- ram_in  in  8  RAM read byte, valid one cycle after its address
- ram_addr  out  ADDR_WIDTH  RAM byte address
- ram_wr  out  1  1 = write ram_out at ram_addr this cycle
- ram_out  out  8  RAM write byte
- busy  out  1  high whenever state != IDLE

## Operation
- States are IDLE, READ, WRITE and DONE.
- IDLE:
  - Samples the requests.
  - If only one request is high, that requester is granted.
  - If both are high:
    - FAIR=0: load/store is granted.
    - FAIR=1: the requester that lost the previous contention is granted. After reset, load/store wins first.
  - On grant, the arbiter latches the address, size, we and wdata. The byte count n is 1, 2 or 4; fetch always uses n=4.
  - It then moves to READ or WRITE with byte index k=0.
- READ:
  - Drives ram_addr = base+k with ram_wr=0 for k = 0..n-1.
  - Captures ram_in into result byte k-1 on the following cycle.
  - Stays one extra cycle after k=n-1 to capture the last byte, then moves to DONE.
- WRITE:
  - Drives ram_addr = base+k, ram_out = wdata byte k and ram_wr=1 for k = 0..n-1.
  - Moves to DONE after the k=n-1 cycle.
- DONE:
  - Pulses if_done or ls_done for exactly one cycle, with its data output valid.
  - Returns to IDLE.
  - The requester must drop req by the edge ending the DONE cycle. Otherwise the request is treated as a new one.
- Address arithmetic is modulo 2^ADDR_WIDTH, so base+k wraps past all-ones to 0.
- Unwritten upper result bits are 0 for byte and half loads.
- flush high on any edge:
  - Aborts an in-progress READ (fetch or load) and returns to IDLE.
  - No done pulse is produced; data outputs keep their previous value.
  - flush in IDLE suppresses the grant that cycle.
  - WRITE is never aborted: committed stores complete, and ls_done still pulses.
  - flush is ignored in DONE, so the pulse is delivered.
- When idle, ram_wr=0 and ram_addr holds its last value.

## Timing
- Reset values: if_done=0, ls_done=0, if_data=0, ls_rdata=0, ram_addr=0, ram_wr=0, ram_out=0, busy=0. State returns to IDLE and the fairness token is reset to load/store.
- rst overrides everything, including a mid-transaction WRITE; any partial write is abandoned.
- Timing is counted from the edge at which IDLE samples req (cycle 0).
- Read latency:
  - Addresses are driven in cycles 1..n, with bytes captured at the edges ending cycles 2..n+1.
  - done is high in cycle n+2; a fetch pulses in cycle 6.
- Write latency: ram_wr is high in cycles 1..n, and done is high in cycle n+1.
- Minimum spacing: the next grant is sampled at the edge ending the DONE cycle+1. One IDLE cycle separates back-to-back transactions.
- Handshake: request fields must stay stable from cycle 0 until done. The arbiter samples them only at grant.
- done pulses never overlap, and at most one RAM cycle is issued per clock.

## Test plan
- Single fetch:
  - Stimulus: if_addr=0x100, RAM[0x100..0x103]=11,22,33,44.
  - Response: addresses 0x100..0x103 in cycles 1..4, if_done in cycle 6 only, if_data=0x44332211.
- Store then load:
  - Stimulus: SH ls_addr=0x200, wdata=0xABCD1234, then LHU of the same address.
  - Response: ram_wr in 2 cycles writing 34,12; ls_done 3 cycles after grant; load returns ls_rdata=0x00001234.
- Contention, FAIR=1:
  - Stimulus: both requests held continuously, with requesters re-raising req after each done.
  - Response: grants go load/store, fetch, load/store, fetch. With FAIR=0, load/store wins every grant.
- Flush mid-fetch:
  - Stimulus: flush asserted in cycle 3 of a fetch.
  - Response: no if_done, busy low the next cycle, if_data unchanged.
- Flush during store:
  - Stimulus: flush asserted in cycle 2 of an SW to 0x300.
  - Response: all 4 bytes are written and ls_done pulses in cycle 5.
- Wrap and reset:
  - Stimulus: LW at 0xFFFFFFFE.
  - Response: addresses FFFFFFFE, FFFFFFFF, 0, 1.
  - Stimulus: rst asserted in cycle 2 of a store.
  - Response: all outputs 0 the next cycle, with no done pulse.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one byte-wide RAM port between the instruction-fetch queue and the
// load/store buffer. Each granted transaction is split into byte-wide RAM
// cycles. Reads are reassembled into a little-endian 32-bit word. Every
// completed transaction gives one done pulse.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   if_req/if_addr        fetch request (always 4 bytes)
//   if_done/if_data       fetch completion pulse and fetched word
//   ls_req/ls_we/ls_size  load/store request, direction and size (1/2/4 bytes)
//   ls_addr/ls_wdata      load/store base address and store data
//   ls_done/ls_rdata      load/store completion pulse and zero-extended load data
//   flush                 aborts speculative reads; stores always complete
//   ram_in                RAM read byte, valid one cycle after its address
//   ram_addr/ram_wr/ram_out  RAM byte address, write strobe and write byte
//   busy                  high whenever a transaction is in progress
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter bit FAIR       = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_done,
    output logic [31:0]           if_data,
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [1:0]            ls_size,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [31:0]           ls_wdata,
    output logic                  ls_done,
    output logic [31:0]           ls_rdata,
    input  logic                  flush,
    input  logic [7:0]            ram_in,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_wr,
    output logic [7:0]            ram_out,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] base;
    logic [2:0]            n;
    logic [2:0]            cnt;
    logic                  is_fetch;
    logic [31:0]           wdata;
    logic [31:0]           rbuf;
    logic                  prio_if;

    logic                  contend;
    logic                  grant_if;
    logic                  grant_ls;
    logic [2:0]            ls_n;
    logic [1:0]            byte_idx;
    logic [31:0]           merged;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [7:0]            wbyte;

    assign busy = (state != IDLE);

    // Grant selection. prio_if remembers who lost the last contention;
    // a flush in IDLE blocks any grant that cycle.
    always_comb begin
        contend  = if_req && ls_req;
        grant_if = 1'b0;
        grant_ls = 1'b0;
        if (!flush) begin
            if (contend) begin
                if (FAIR && prio_if) grant_if = 1'b1;
                else                 grant_ls = 1'b1;
            end else if (if_req) begin
                grant_if = 1'b1;
            end else if (ls_req) begin
                grant_ls = 1'b1;
            end
        end
    end

    // cnt counts the edges since the grant. In READ the byte on ram_in at
    // edge cnt belongs to the address driven at cnt-1, so the byte index is cnt-2.
    always_comb begin
        case (ls_size)
            2'b00:   ls_n = 3'd1;
            2'b01:   ls_n = 3'd2;
            default: ls_n = 3'd4;
        endcase
        byte_idx  = 2'(cnt - 3'd2);
        merged    = rbuf | ({24'b0, ram_in} << {byte_idx, 3'b000});
        next_addr = base + ADDR_WIDTH'(cnt);
        wbyte     = 8'(wdata >> {cnt[1:0], 3'b000});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            base     <= '0;
            n        <= 3'd0;
            cnt      <= 3'd0;
            is_fetch <= 1'b0;
            wdata    <= 32'd0;
            rbuf     <= 32'd0;
            prio_if  <= 1'b0;
            if_done  <= 1'b0;
            ls_done  <= 1'b0;
            if_data  <= 32'd0;
            ls_rdata <= 32'd0;
            ram_addr <= '0;
            ram_wr   <= 1'b0;
            ram_out  <= 8'd0;
        end else begin
            if_done <= 1'b0;
            ls_done <= 1'b0;
            case (state)
                IDLE: begin
                    ram_wr <= 1'b0;
                    if (grant_if || grant_ls) begin
                        // The loser of a contention gets priority next time.
                        if (contend && FAIR) prio_if <= grant_ls;
                        is_fetch <= grant_if;
                        base     <= grant_if ? if_addr : ls_addr;
                        ram_addr <= grant_if ? if_addr : ls_addr;
                        n        <= grant_if ? 3'd4 : ls_n;
                        wdata    <= ls_wdata;
                        rbuf     <= 32'd0;
                        cnt      <= 3'd1;
                        if (grant_ls && ls_we) begin
                            state   <= WRITE;
                            ram_wr  <= 1'b1;
                            ram_out <= ls_wdata[7:0];
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        if (cnt >= 3'd2) rbuf <= merged;
                        if (cnt < n) ram_addr <= next_addr;
                        if (cnt == n + 3'd1) begin
                            state <= DONE;
                            if (is_fetch) begin
                                if_done <= 1'b1;
                                if_data <= merged;
                            end else begin
                                ls_done  <= 1'b1;
                                ls_rdata <= merged;
                            end
                        end
                        cnt <= cnt + 3'd1;
                    end
                end
                WRITE: begin
                    // Stores ignore flush: once granted they always complete.
                    if (cnt < n) begin
                        ram_addr <= next_addr;
                        ram_out  <= wbyte;
                        cnt      <= cnt + 3'd1;
                    end else begin
                        ram_wr  <= 1'b0;
                        state   <= DONE;
                        ls_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter. The main instance (FAIR=1) is connected to a
// byte RAM model with a registered read and a backdoor preload port. A second
// instance (FAIR=0) has its own request lines and is used only to observe
// grant order under contention.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        ls_req;
    logic        ls_we;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic        flush;
    logic [7:0]  ram_in;
    logic [31:0] ram_addr;
    logic        ram_wr;
    logic [7:0]  ram_out;
    logic        busy;

    logic        if_req_f0;
    logic        ls_req_f0;
    logic        if_done_f0;
    logic [31:0] if_data_f0;
    logic        ls_done_f0;
    logic [31:0] ls_rdata_f0;
    logic [7:0]  ram_in_f0;
    logic [31:0] ram_addr_f0;
    logic        ram_wr_f0;
    logic [7:0]  ram_out_f0;
    logic        busy_f0;

    logic [7:0]  mem [0:4095];
    logic        bd_we;
    logic [11:0] bd_addr;
    logic [31:0] bd_data;

    int tests_run;
    int tests_failed;

    mem_arbiter #(.ADDR_WIDTH(32), .FAIR(1'b1)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
        .flush(flush), .ram_in(ram_in), .ram_addr(ram_addr), .ram_wr(ram_wr),
        .ram_out(ram_out), .busy(busy)
    );

    mem_arbiter #(.ADDR_WIDTH(32), .FAIR(1'b0)) dut_f0 (
        .clk(clk), .rst(rst),
        .if_req(if_req_f0), .if_addr(if_addr), .if_done(if_done_f0), .if_data(if_data_f0),
        .ls_req(ls_req_f0), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_done(ls_done_f0), .ls_rdata(ls_rdata_f0),
        .flush(flush), .ram_in(ram_in_f0), .ram_addr(ram_addr_f0), .ram_wr(ram_wr_f0),
        .ram_out(ram_out_f0), .busy(busy_f0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ram_in_f0 = 8'h00;

    // Byte RAM: read data appears the cycle after its address.
    always @(posedge clk) begin
        ram_in <= mem[ram_addr[11:0]];
        if (ram_wr) mem[ram_addr[11:0]] <= ram_out;
        if (bd_we) begin
            for (int i = 0; i < 4; i++) mem[bd_addr + 12'(i)] <= bd_data[8*i +: 8];
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [1:0] size,
                                 input logic [31:0] addr, input logic [31:0] wd);
        ls_we    = we;
        ls_size  = size;
        ls_addr  = addr;
        ls_wdata = wd;
        ls_req   = 1'b1;
    endtask

    task automatic loadWord(input logic [11:0] addr, input logic [31:0] word);
        bd_addr = addr;
        bd_data = word;
        bd_we   = 1'b1;
        cyc();
        bd_we   = 1'b0;
    endtask

    task automatic checkResetOutputs(input string prefix);
        checkOutput({prefix, "_if_done"},  32'(if_done),  32'd0);
        checkOutput({prefix, "_ls_done"},  32'(ls_done),  32'd0);
        checkOutput({prefix, "_if_data"},  if_data,       32'd0);
        checkOutput({prefix, "_ls_rdata"}, ls_rdata,      32'd0);
        checkOutput({prefix, "_ram_addr"}, ram_addr,      32'd0);
        checkOutput({prefix, "_ram_wr"},   32'(ram_wr),   32'd0);
        checkOutput({prefix, "_ram_out"},  32'(ram_out),  32'd0);
        checkOutput({prefix, "_busy"},     32'(busy),     32'd0);
    endtask

    initial begin
        logic [1:0]  ord1 [4];
        logic [1:0]  ord0 [4];
        logic [31:0] word;
        logic [31:0] wrap_exp [4];
        int g1;
        int g0;
        int saw_done;

        tests_run    = 0;
        tests_failed = 0;
        rst       = 1'b1;
        if_req    = 1'b0;
        if_addr   = 32'd0;
        ls_req    = 1'b0;
        ls_we     = 1'b0;
        ls_size   = 2'b00;
        ls_addr   = 32'd0;
        ls_wdata  = 32'd0;
        flush     = 1'b0;
        if_req_f0 = 1'b0;
        ls_req_f0 = 1'b0;
        bd_we     = 1'b0;
        bd_addr   = 12'd0;
        bd_data   = 32'd0;
        for (int i = 0; i < 4; i++) begin
            ord1[i] = 2'd0;
            ord0[i] = 2'd0;
        end

        repeat (3) cyc();
        checkResetOutputs("reset");
        rst = 1'b0;

        // Single fetch of 0x100.
        $display("[TB] single fetch");
        loadWord(12'h100, 32'h44332211);
        if_addr = 32'h100;
        if_req  = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            cyc();
            if (c <= 4) checkOutput("fetch_addr", ram_addr, 32'h100 + 32'(c - 1));
            if (c == 1) begin
                checkOutput("fetch_busy", 32'(busy), 32'd1);
                checkOutput("fetch_ram_wr", 32'(ram_wr), 32'd0);
            end
            checkOutput("fetch_done", 32'(if_done), 32'(c == 6));
        end
        checkOutput("fetch_data", if_data, 32'h44332211);
        if_req = 1'b0;
        cyc();
        checkOutput("fetch_idle", 32'(busy), 32'd0);

        // Halfword store then halfword load of 0x200.
        $display("[TB] store then load");
        applyStimulus(1'b1, 2'b01, 32'h200, 32'hABCD1234);
        cyc();
        checkOutput("sh_wr1", 32'(ram_wr), 32'd1);
        checkOutput("sh_addr1", ram_addr, 32'h200);
        checkOutput("sh_out1", 32'(ram_out), 32'h34);
        cyc();
        checkOutput("sh_wr2", 32'(ram_wr), 32'd1);
        checkOutput("sh_addr2", ram_addr, 32'h201);
        checkOutput("sh_out2", 32'(ram_out), 32'h12);
        checkOutput("sh_early_done", 32'(ls_done), 32'd0);
        cyc();
        checkOutput("sh_wr3", 32'(ram_wr), 32'd0);
        checkOutput("sh_done", 32'(ls_done), 32'd1);
        ls_req = 1'b0;
        cyc();
        applyStimulus(1'b0, 2'b01, 32'h200, 32'h0);
        for (int c = 1; c <= 4; c++) begin
            cyc();
            if (c <= 2) checkOutput("lh_addr", ram_addr, 32'h200 + 32'(c - 1));
            checkOutput("lh_done", 32'(ls_done), 32'(c == 4));
        end
        checkOutput("lh_data", ls_rdata, 32'h00001234);
        ls_req = 1'b0;
        cyc();

        // Contention: both requesters re-raise after each done.
        $display("[TB] contention");
        if_addr = 32'h100;
        if_req  = 1'b1;
        applyStimulus(1'b0, 2'b00, 32'h101, 32'h0);
        if_req_f0 = 1'b1;
        ls_req_f0 = 1'b1;
        g1 = 0;
        g0 = 0;
        for (int c = 0; c < 40; c++) begin
            cyc();
            if (if_done) begin
                if (g1 < 4) ord1[g1] = 2'd2;
                g1++;
                if_req = 1'b0;
            end else begin
                if_req = 1'b1;
            end
            if (ls_done) begin
                if (g1 < 4) ord1[g1] = 2'd1;
                g1++;
                ls_req = 1'b0;
            end else begin
                ls_req = 1'b1;
            end
            if (if_done_f0) begin
                if (g0 < 4) ord0[g0] = 2'd2;
                g0++;
                if_req_f0 = 1'b0;
            end else begin
                if_req_f0 = 1'b1;
            end
            if (ls_done_f0) begin
                if (g0 < 4) ord0[g0] = 2'd1;
                g0++;
                ls_req_f0 = 1'b0;
            end else begin
                ls_req_f0 = 1'b1;
            end
        end
        if_req    = 1'b0;
        ls_req    = 1'b0;
        if_req_f0 = 1'b0;
        ls_req_f0 = 1'b0;
        repeat (12) cyc();
        checkOutput("fair1_grant0", 32'(ord1[0]), 32'd1);
        checkOutput("fair1_grant1", 32'(ord1[1]), 32'd2);
        checkOutput("fair1_grant2", 32'(ord1[2]), 32'd1);
        checkOutput("fair1_grant3", 32'(ord1[3]), 32'd2);
        for (int i = 0; i < 4; i++) checkOutput("fair0_grant", 32'(ord0[i]), 32'd1);
        checkOutput("lbu_data", ls_rdata, 32'h00000022);
        checkOutput("contend_idle", 32'(busy), 32'd0);

        // Flush during a fetch of 0x110.
        $display("[TB] flush mid-fetch");
        loadWord(12'h110, 32'hDDCCBBAA);
        if_addr = 32'h110;
        if_req  = 1'b1;
        cyc();
        cyc();
        cyc();
        checkOutput("flush_fetch_addr3", ram_addr, 32'h112);
        flush = 1'b1;
        cyc();
        checkOutput("flush_fetch_busy", 32'(busy), 32'd0);
        flush  = 1'b0;
        if_req = 1'b0;
        saw_done = 0;
        for (int c = 0; c < 6; c++) begin
            cyc();
            if (if_done) saw_done++;
        end
        checkOutput("flush_fetch_nodone", 32'(saw_done), 32'd0);
        checkOutput("flush_fetch_data", if_data, 32'h44332211);

        // Flush during a word store: the store still completes.
        $display("[TB] flush during store");
        word = 32'h87654321;
        applyStimulus(1'b1, 2'b10, 32'h300, word);
        for (int c = 1; c <= 5; c++) begin
            cyc();
            if (c <= 4) begin
                checkOutput("sw_wr", 32'(ram_wr), 32'd1);
                checkOutput("sw_addr", ram_addr, 32'h300 + 32'(c - 1));
                checkOutput("sw_out", 32'(ram_out), 32'(word[8*(c-1) +: 8]));
            end
            checkOutput("sw_done", 32'(ls_done), 32'(c == 5));
            if (c == 2) flush = 1'b1;
            if (c == 5) begin
                flush  = 1'b0;
                ls_req = 1'b0;
            end
        end
        cyc();

        // Word load wrapping past the top of the address space.
        $display("[TB] address wrap");
        loadWord(12'hFFE, 32'h0D0C0B0A);
        wrap_exp[0] = 32'hFFFFFFFE;
        wrap_exp[1] = 32'hFFFFFFFF;
        wrap_exp[2] = 32'h00000000;
        wrap_exp[3] = 32'h00000001;
        applyStimulus(1'b0, 2'b10, 32'hFFFFFFFE, 32'h0);
        for (int c = 1; c <= 6; c++) begin
            cyc();
            if (c <= 4) checkOutput("wrap_addr", ram_addr, wrap_exp[c-1]);
            checkOutput("wrap_done", 32'(ls_done), 32'(c == 6));
        end
        checkOutput("wrap_data", ls_rdata, 32'h0D0C0B0A);
        ls_req = 1'b0;
        cyc();

        // Reset in the middle of a store.
        $display("[TB] reset mid-store");
        applyStimulus(1'b1, 2'b10, 32'h400, 32'hCAFEF00D);
        cyc();
        cyc();
        rst    = 1'b1;
        ls_req = 1'b0;
        cyc();
        checkResetOutputs("midrst");
        rst = 1'b0;
        saw_done = 0;
        for (int c = 0; c < 6; c++) begin
            cyc();
            if (ls_done || if_done) saw_done++;
        end
        checkOutput("midrst_nodone", 32'(saw_done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
